// File: rtl/tt_fa_pkg.sv
// Shared constants and result record for the tt_um_full_adder tile.
// Pin bit positions live here so the RTL and the harness agree on the pinout.
package tt_fa_pkg;

    localparam int WIDTH = 4;
    localparam logic [7:0] UIO_OE_MASK = 8'hFC;

    // uio_in control bits
    localparam int UIO_CIN_BIT = 0;
    localparam int UIO_SUB_BIT = 1;
    localparam int UIO_ACC_BIT = 2;

    // uo_out result/flag positions
    localparam int UO_COUT_BIT = 4;
    localparam int UO_OVF_BIT  = 5;
    localparam int UO_ZERO_BIT = 6;
    localparam int UO_NEG_BIT  = 7;

    // uio_out status positions
    localparam int UIO_VALID_BIT = 2;
    localparam int UIO_CARRY_LSB = 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             neg;
        logic [WIDTH:1]   carry;
    } fa_result_t;

    function automatic logic [7:0] pack_uo(input fa_result_t r);
        logic [7:0] v;
        v = '0;
        v[WIDTH-1:0]  = r.sum;
        v[UO_COUT_BIT] = r.cout;
        v[UO_OVF_BIT]  = r.ovf;
        v[UO_ZERO_BIT] = r.zero;
        v[UO_NEG_BIT]  = r.neg;
        return v;
    endfunction

    function automatic logic [7:0] pack_uio(input fa_result_t r, input logic valid);
        logic [7:0] v;
        v = '0;
        v[UIO_CARRY_LSB +: WIDTH] = r.carry;
        v[UIO_VALID_BIT]          = valid;
        return v;
    endfunction

endpackage

// File: rtl/tt_um_full_adder_if.sv
// Tiny Tapeout tile pin bundle; the harness side drives inputs (master),
// the tile side consumes them (slave). Clock and reset stay separate.
interface tt_um_full_adder_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );

endinterface

// File: rtl/fa_cell.sv
// One-bit full adder cell; chained by the tile into a ripple-carry adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/tt_um_full_adder.sv
// 4-bit ripple add/subtract tile with a registered result, flag and carry bank.
// Optional running-accumulator mode is built when FA_ACCUM_EN is defined.
module tt_um_full_adder
    import tt_fa_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;
    logic             cin;
    logic             sub;

    fa_result_t res_d;
    fa_result_t res_q;
    logic       valid_q;

    assign op_b = ui_in[7:4];
    assign cin  = uio_in[UIO_CIN_BIT];
    assign sub  = uio_in[UIO_SUB_BIT];

`ifdef FA_ACCUM_EN
    // Accumulate feeds back the registered sum, which is 0 until the first result.
    assign op_a = uio_in[UIO_ACC_BIT] ? res_q.sum : ui_in[3:0];
    logic unused_inputs;
    assign unused_inputs = &{1'b0, uio_in[7:3]};
`else
    assign op_a = ui_in[3:0];
    logic unused_inputs;
    assign unused_inputs = &{1'b0, uio_in[7:2]};
`endif

    // Subtraction is A + ~B + ~cin, so cout=1 reads as "no borrow".
    assign b_eff    = sub ? ~op_b : op_b;
    assign carry[0] = sub ^ cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        fa_cell u_cell (
            .a  (op_a[gi]),
            .b  (b_eff[gi]),
            .ci (carry[gi]),
            .s  (sum[gi]),
            .co (carry[gi+1])
        );
    end

    // NOTE: every field gets a value on every pass, so no latch can be inferred.
    always_comb begin
        res_d       = '0;
        res_d.sum   = sum;
        res_d.cout  = carry[WIDTH];
        res_d.ovf   = carry[WIDTH] ^ carry[WIDTH-1];
        res_d.zero  = (sum == '0);
        res_d.neg   = sum[WIDTH-1];
        res_d.carry = carry[WIDTH:1];
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else if (ena) begin
            res_q   <= res_d;
            valid_q <= 1'b1;
        end
    end

    assign uo_out  = pack_uo(res_q);
    assign uio_out = pack_uio(res_q, valid_q);
    assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_full_adder.sv
// Self-checking bench for tt_um_full_adder: directed table, corner sequences
// and randomized traffic against an arithmetic reference model.
module tb_tt_um_full_adder;

    logic clk;
    logic rst_n;

    tt_um_full_adder_if bus ();

    tt_um_full_adder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (bus.ena),
        .ui_in   (bus.ui_in),
        .uio_in  (bus.uio_in),
        .uo_out  (bus.uo_out),
        .uio_out (bus.uio_out),
        .uio_oe  (bus.uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: last captured outputs and accumulator value.
    logic [7:0] exp_uo  = 8'h00;
    logic [7:0] exp_uio = 8'h00;
    int         exp_s   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    function automatic void model_calc(input int a, input int b, input int cin, input int sub,
                                       output logic [7:0] uo, output logic [7:0] uio);
        int bb, c0, total, s, sa, sb, sv, m, ci;
        bb    = sub ? 15 - b : b;
        c0    = sub ? 1 - cin : cin;
        total = a + bb + c0;
        s     = total % 16;
        sa    = (a >= 8) ? a - 16 : a;
        sb    = (b >= 8) ? b - 16 : b;
        sv    = sub ? sa - sb - cin : sa + sb + cin;
        uo    = 8'(s);
        uo[4] = (total >= 16);
        uo[5] = (sv > 7) || (sv < -8);
        uo[6] = (s == 0);
        uo[7] = (s >= 8);
        uio   = 8'h04;
        for (int i = 1; i <= 4; i++) begin
            m  = 1 << i;
            ci = ((a % m) + (bb % m) + c0) >> i;
            uio[3+i] = ci[0];
        end
    endfunction

    task automatic model_reset();
        exp_uo  = 8'h00;
        exp_uio = 8'h00;
        exp_s   = 0;
    endtask

    // Apply one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic en, input logic [7:0] ui, input logic [7:0] uio,
                        input bit do_check, input string tag);
        int a;
        bus.ena    = en;
        bus.ui_in  = ui;
        bus.uio_in = uio;
        @(posedge clk);
        #1;
        if (en) begin
            a = int'(ui[3:0]);
`ifdef FA_ACCUM_EN
            if (uio[2]) a = exp_s;
`endif
            model_calc(a, int'(ui[7:4]), int'(uio[0]), int'(uio[1]), exp_uo, exp_uio);
            exp_s = int'(exp_uo[3:0]);
        end
        if (do_check) begin
            check({tag, " uo_out"}, bus.uo_out, exp_uo);
            check({tag, " uio_out"}, bus.uio_out, exp_uio);
        end
    endtask

    typedef struct {
        logic       ena;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
        string      name;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 4'd3,  4'd5,  1'b0, 1'b0, 8'hA8, 8'h74, "add 3+5"};
        vecs[1] = '{1'b1, 4'd15, 4'd15, 1'b1, 1'b0, 8'h9F, 8'hF4, "add 15+15+1"};
        vecs[2] = '{1'b1, 4'd9,  4'd4,  1'b0, 1'b1, 8'h35, 8'hB4, "sub 9-4"};
        vecs[3] = '{1'b1, 4'd4,  4'd9,  1'b0, 1'b1, 8'hAB, 8'h44, "sub 4-9"};
        vecs[4] = '{1'b1, 4'd8,  4'd8,  1'b0, 1'b1, 8'h50, 8'hF4, "sub 8-8 zero"};
        vecs[5] = '{1'b0, 4'd1,  4'd2,  1'b0, 1'b0, 8'h50, 8'hF4, "ena=0 hold"};
        vecs[6] = '{1'b1, 4'd0,  4'd0,  1'b1, 1'b1, 8'h8F, 8'h04, "sub 0-0-1"};
        vecs[7] = '{1'b1, 4'd7,  4'd1,  1'b0, 1'b0, 8'hA8, 8'h74, "add 7+1 ovf"};

        rst_n      = 1'b0;
        bus.ena    = 1'b0;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        #12;
        check("reset uo_out", bus.uo_out, 8'h00);
        check("reset uio_out", bus.uio_out, 8'h00);
        check("reset uio_oe", bus.uio_oe, 8'hFC);

        // Release with the tile disabled: nothing may be captured.
        rst_n = 1'b1;
        step(1'b0, 8'h53, 8'h00, 1'b0, "");
        step(1'b0, 8'hFF, 8'h03, 1'b0, "");
        check("disabled uo_out", bus.uo_out, 8'h00);
        check("disabled uio_out", bus.uio_out, 8'h00);

        foreach (vecs[i]) begin
            step(vecs[i].ena, {vecs[i].b, vecs[i].a}, {6'b0, vecs[i].sub, vecs[i].cin}, 1'b0, "");
            check({vecs[i].name, " uo_out"}, bus.uo_out, vecs[i].exp_uo);
            check({vecs[i].name, " uio_out"}, bus.uio_out, vecs[i].exp_uio);
        end

        // Accumulate sequence from reset, A pin held at 5, B=3.
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
`ifdef FA_ACCUM_EN
        step(1'b1, 8'h35, 8'h04, 1'b0, "");
        check("accum S #1", {4'h0, bus.uo_out[3:0]}, 8'h03);
        step(1'b1, 8'h35, 8'h04, 1'b0, "");
        check("accum S #2", {4'h0, bus.uo_out[3:0]}, 8'h06);
        step(1'b1, 8'h35, 8'h04, 1'b0, "");
        check("accum S #3", {4'h0, bus.uo_out[3:0]}, 8'h09);
`else
        step(1'b1, 8'h35, 8'h04, 1'b0, "");
        check("acc ignored S #1", {4'h0, bus.uo_out[3:0]}, 8'h08);
        step(1'b1, 8'h35, 8'h04, 1'b0, "");
        check("acc ignored S #2", {4'h0, bus.uo_out[3:0]}, 8'h08);
        step(1'b1, 8'h35, 8'h04, 1'b0, "");
        check("acc ignored S #3", {4'h0, bus.uo_out[3:0]}, 8'h08);
`endif

        // Mid-stream reset must clear outputs without waiting for an edge.
        step(1'b1, 8'hFF, 8'h01, 1'b1, "pre-reset");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid reset uo_out", bus.uo_out, 8'h00);
        check("mid reset uio_out", bus.uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 7) != 0), 8'($urandom), 8'($urandom), 1'b1, "random");
        end
        check("final uio_oe", bus.uio_oe, 8'hFC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
